// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the read-master state type.
// Imported by the refill read master.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_8B = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/axi_rd_burst_master.sv
// Cache line refill master: one request becomes one INCR burst,
// the R beats fill a line buffer returned with a sticky error flag.
module axi_rd_burst_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    output logic [BEATS*DATA_W-1:0] resp_data,
    output logic                    resp_err,
    output logic [ADDR_W-1:0]       araddr,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [1:0]              arburst,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    input  logic [DATA_W-1:0]       rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    input  logic                    rlast,
    output logic                    rready
);

    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

    rd_state_e        state;
    rd_state_e        state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic             err;
    logic             accept;
    logic             beat_hs;
    logic             is_last;

    assign arburst = BURST_INCR;
    assign arlen   = 8'(BEATS - 1);
    assign arsize  = 3'($clog2(DATA_W / 8));

    assign accept  = req_valid && req_ready;
    assign beat_hs = rvalid && rready;
    assign is_last = (beat_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_AR;
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid && is_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                resp_err   = err;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // An early or missing rlast only flags the line; the beat count ends it.
    always_ff @(posedge clk) begin
        if (rst) begin
            araddr    <= '0;
            beat_cnt  <= '0;
            err       <= 1'b0;
            resp_data <= '0;
        end else begin
            if (accept) begin
                araddr   <= req_addr & LINE_MASK;
                beat_cnt <= '0;
                err      <= 1'b0;
            end
            if (beat_hs) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (beat_cnt == CNT_W'(k))
                        resp_data[k*DATA_W +: DATA_W] <= rdata;
                end
                beat_cnt <= beat_cnt + CNT_W'(1);
                err      <= err | (rresp != RESP_OKAY) | (rlast != is_last);
            end
        end
    end

endmodule
